// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding and width default for the alu block
package alu_pkg;

   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_NOT   = 4'b0101,
      OP_INC   = 4'b0110,
      OP_DEC   = 4'b0111,
      OP_PASSB = 4'b1000,
      OP_SHL   = 4'b1001,
      OP_SHR   = 4'b1010
   } opcode_t;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operation/result bundle between the alu and its driver
interface alu_if
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
);
   logic [3:0]        opcode;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [DATA_W-1:0] result;
   logic              zero_flag;
   logic              carry_flag;

   modport master (
      output opcode, A, B,
      input  result, zero_flag, carry_flag
   );

   modport slave (
      input  opcode, A, B,
      output result, zero_flag, carry_flag
   );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational next-result and next-carry computation
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] next_result,
   output logic              next_carry
);

   localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

   logic [DATA_W:0] a_ext;
   logic [DATA_W:0] b_ext;
   logic [DATA_W:0] wide;

   assign a_ext = {1'b0, a};
   assign b_ext = {1'b0, b};

   // One extra bit on arithmetic ops carries the carry out / borrow; reserved opcodes fall to zero.
   always_comb begin
      wide        = '0;
      next_result = '0;
      next_carry  = 1'b0;
      case (opcode)
         OP_ADD: begin
            wide        = a_ext + b_ext;
            next_result = wide[DATA_W-1:0];
            next_carry  = wide[DATA_W];
         end
         OP_SUB: begin
            wide        = a_ext - b_ext;
            next_result = wide[DATA_W-1:0];
            next_carry  = wide[DATA_W];
         end
         OP_AND:   next_result = a & b;
         OP_OR:    next_result = a | b;
         OP_XOR:   next_result = a ^ b;
         OP_NOT:   next_result = ~a;
         OP_INC: begin
            wide        = a_ext + ONE;
            next_result = wide[DATA_W-1:0];
            next_carry  = wide[DATA_W];
         end
         OP_DEC: begin
            wide        = a_ext - ONE;
            next_result = wide[DATA_W-1:0];
            next_carry  = wide[DATA_W];
         end
         OP_PASSB: next_result = b;
         OP_SHL: begin
            next_result = {a[DATA_W-2:0], 1'b0};
            next_carry  = a[DATA_W-1];
         end
         OP_SHR: begin
            next_result = {1'b0, a[DATA_W-1:1]};
            next_carry  = a[0];
         end
         default: begin
            next_result = '0;
            next_carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered alu with zero and carry flags
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   alu_if.slave bus
);

   logic [DATA_W-1:0] next_result;
   logic              next_carry;

   alu_core #(.DATA_W(DATA_W)) u_core (
      .opcode      (bus.opcode),
      .a           (bus.A),
      .b           (bus.B),
      .next_result (next_result),
      .next_carry  (next_carry)
   );

   // Register the outputs; zero is taken from the truncated result so a carry-out still reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.result     <= '0;
         bus.zero_flag  <= 1'b1;
         bus.carry_flag <= 1'b0;
      end else begin
         bus.result     <= next_result;
         bus.zero_flag  <= (next_result == '0);
         bus.carry_flag <= next_carry;
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench: directed table, reset sequences, random vs model
module tb_alu;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   alu_if #(.DATA_W(8)) bus ();

   alu #(.DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z;
      logic       c;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [7:0] r, input logic z, input logic c);
      check({name, ".result"}, {1'b0, bus.result}, {1'b0, r});
      check({name, ".zero"},   {8'd0, bus.zero_flag}, {8'd0, z});
      check({name, ".carry"},  {8'd0, bus.carry_flag}, {8'd0, c});
   endtask

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.opcode = op;
      bus.A      = a;
      bus.B      = b;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic void model(input int op, input int a, input int b,
                                 output logic [7:0] r, output logic z, output logic c);
      int v;
      int cy;
      cy = 0;
      case (op)
         0:  begin v = a + b;  cy = (v > 255); end
         1:  begin v = a - b;  cy = (a < b);   end
         2:  v = a & b;
         3:  v = a | b;
         4:  v = a ^ b;
         5:  v = 255 - a;
         6:  begin v = a + 1;  cy = (a == 255); end
         7:  begin v = a - 1;  cy = (a == 0);   end
         8:  v = b;
         9:  begin v = a * 2;  cy = (a >= 128); end
         10: begin v = a / 2;  cy = a % 2;      end
         default: v = 0;
      endcase
      v = ((v % 256) + 256) % 256;
      r = 8'(v);
      z = (v == 0);
      c = (cy != 0);
   endfunction

   initial begin
      logic [7:0] er;
      logic       ez;
      logic       ec;

      vecs.push_back('{4'b0000, 8'd100,  8'd120, 8'd220,  1'b0, 1'b0});
      vecs.push_back('{4'b0000, 8'd200,  8'd100, 8'd44,   1'b0, 1'b1});
      vecs.push_back('{4'b0000, 8'd200,  8'd56,  8'd0,    1'b1, 1'b1});
      vecs.push_back('{4'b0001, 8'd100,  8'd50,  8'd50,   1'b0, 1'b0});
      vecs.push_back('{4'b0001, 8'd50,   8'd100, 8'd206,  1'b0, 1'b1});
      vecs.push_back('{4'b0001, 8'd10,   8'd10,  8'd0,    1'b1, 1'b0});
      vecs.push_back('{4'b0010, 8'hCC,   8'hAA,  8'h88,   1'b0, 1'b0});
      vecs.push_back('{4'b0011, 8'hCC,   8'hAA,  8'hEE,   1'b0, 1'b0});
      vecs.push_back('{4'b0100, 8'hCC,   8'hAA,  8'h66,   1'b0, 1'b0});
      vecs.push_back('{4'b0101, 8'hAA,   8'h13,  8'h55,   1'b0, 1'b0});
      vecs.push_back('{4'b0110, 8'd255,  8'd7,   8'd0,    1'b1, 1'b1});
      vecs.push_back('{4'b0111, 8'd0,    8'd9,   8'd255,  1'b0, 1'b1});
      vecs.push_back('{4'b1000, 8'd77,   8'd123, 8'd123,  1'b0, 1'b0});
      vecs.push_back('{4'b1001, 8'h81,   8'h00,  8'h02,   1'b0, 1'b1});
      vecs.push_back('{4'b1010, 8'h81,   8'h00,  8'h40,   1'b0, 1'b1});
      vecs.push_back('{4'b1111, 8'hFF,   8'hFF,  8'h00,   1'b1, 1'b0});
      vecs.push_back('{4'b1011, 8'h12,   8'h34,  8'h00,   1'b1, 1'b0});

      rst        = 1'b1;
      bus.opcode = 4'b0000;
      bus.A      = 8'd200;
      bus.B      = 8'd100;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_out("reset", 8'd0, 1'b1, 1'b0);

      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b);
         check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].c);
      end

      // Outputs hold between edges even when inputs and rst move.
      drive(4'b0000, 8'd200, 8'd100);
      check_out("add_pre_rst", 8'd44, 1'b0, 1'b1);
      bus.A = 8'd1;
      rst   = 1'b1;
      #3;
      check_out("hold_between_edges", 8'd44, 1'b0, 1'b1);
      bus.A = 8'd200;
      @(posedge clk);
      #1;
      check_out("mid_stream_rst", 8'd0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_out("post_rst", 8'd44, 1'b0, 1'b1);

      for (int n = 0; n < 300; n++) begin
         logic [3:0] op;
         logic [7:0] a;
         logic [7:0] b;
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom);
         b  = 8'($urandom);
         if (n % 10 == 0) a = (n % 20 == 0) ? 8'd0 : 8'd255;
         model(int'(op), int'(a), int'(b), er, ez, ec);
         drive(op, a, b);
         check_out($sformatf("rand%0d_op%0d_a%0d_b%0d", n, op, a, b), er, ez, ec);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
